// File: rtl/ecdsa_arg_table_dma.sv
`timescale 1ns/1ps
// Purpose : moves ARGC operands between the shared 1024-bit BRAM and the ECDSA register file,
//           steered by one MSB-first address-table line (load = mem->rf, store = rf->mem).
// Latency : 3 + 2*argc cycles from accepted start to done (4 + argc with ECDSA_ARG_DMA_PIPELINE_EN).
// Backpressure: none; memory and register file are fixed-latency, start while busy is ignored.
// Build option: define ECDSA_ARG_DMA_PIPELINE_EN to overlap request i+1 with capture i.
module ecdsa_arg_table_dma #(
  parameter int DATA_W   = 1024,
  parameter int ADDR_W   = 17,
  parameter int MAX_ARGC = 32,
  parameter int IDX_W    = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     tbl_base,
  input  logic [7:0]            argc,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_din,
  input  logic [DATA_W-1:0]     mem_dout,
  output logic                  rf_we,
  output logic                  rf_re,
  output logic [IDX_W-1:0]      rf_idx,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [DATA_W-1:0]     rf_rdata
);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ARGC  = 2'd1;
  localparam logic [1:0] ERR_ABORT = 2'd2;
  localparam logic [8:0] MAX_ARGC_W = 9'(MAX_ARGC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TBL_REQ = 3'd1,
    TBL_CAP = 3'd2,
    ARG_REQ = 3'd3,
    ARG_CAP = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          argc_q, argc_d;
  logic [7:0]          i_q, i_d;
  logic [DATA_W-1:0]   tbl_q, tbl_d;
  logic [1:0]          err_q, err_d;
  logic                last_arg;

  // Entry k sits 32*k bits below the top of the line; only the low ADDR_W bits form the address.
  function automatic logic [ADDR_W-1:0] entry_addr(input logic [DATA_W-1:0] tbl,
                                                   input logic [7:0] k);
    int shamt;
    shamt = (DATA_W - 32) - 32 * int'(k);
    return ADDR_W'(tbl >> shamt);
  endfunction

  assign last_arg = (i_q == argc_q - 8'd1);
  assign err      = err_q;

  // State and latched command registers; async reset clears everything including the table.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      base_q  <= '0;
      argc_q  <= '0;
      i_q     <= '0;
      tbl_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      argc_q  <= argc_d;
      i_q     <= i_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and state-decoded memory / register-file strobes.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    argc_d   = argc_q;
    i_d      = i_q;
    tbl_d    = tbl_q;
    err_d    = err_q;
    busy     = 1'b0;
    done     = 1'b0;
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    rf_we    = 1'b0;
    rf_re    = 1'b0;
    rf_idx   = '0;
    rf_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          base_d = tbl_base;
          argc_d = argc;
          i_d    = '0;
          // An oversized request still spends one busy cycle in TBL_REQ (with the
          // memory port held off) so busy rises the cycle after every accepted start.
          err_d   = ({1'b0, argc} > MAX_ARGC_W) ? ERR_ARGC : ERR_OK;
          state_d = TBL_REQ;
        end
      end

      TBL_REQ: begin
        busy = 1'b1;
        if (err_q == ERR_ARGC) begin
          state_d = FIN;
        end else begin
          mem_en   = 1'b1;
          mem_addr = base_q;
          state_d  = TBL_CAP;
        end
      end

      TBL_CAP: begin
        busy    = 1'b1;
        tbl_d   = mem_dout;
        state_d = (argc_q == 8'd0) ? FIN : ARG_REQ;
      end

      ARG_REQ: begin
        busy = 1'b1;
        if (!mode_q) begin
          mem_en   = 1'b1;
          mem_addr = entry_addr(tbl_q, i_q);
        end else begin
          rf_re  = 1'b1;
          rf_idx = i_q[IDX_W-1:0];
        end
        state_d = ARG_CAP;
      end

      ARG_CAP: begin
        busy = 1'b1;
        if (!mode_q) begin
          rf_we    = 1'b1;
          rf_idx   = i_q[IDX_W-1:0];
          rf_wdata = mem_dout;
        end else begin
          mem_en   = 1'b1;
          mem_we   = '1;
          mem_addr = entry_addr(tbl_q, i_q);
          mem_din  = rf_rdata;
        end
        i_d = i_q + 8'd1;
        if (last_arg) begin
          state_d = FIN;
        end else begin
`ifdef ECDSA_ARG_DMA_PIPELINE_EN
          // Issue the next request on the port the current capture leaves free;
          // an abort this cycle drops it so nothing is left in flight.
          if (!abort) begin
            if (!mode_q) begin
              mem_en   = 1'b1;
              mem_addr = entry_addr(tbl_q, i_d);
            end else begin
              rf_re  = 1'b1;
              rf_idx = i_d[IDX_W-1:0];
            end
          end
          state_d = ARG_CAP;
`else
          state_d = ARG_REQ;
`endif
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort only redirects the next state; any write strobed this cycle still lands.
    if (abort && (state_q != IDLE) && (state_q != FIN)) begin
      state_d = FIN;
      err_d   = ERR_ABORT;
    end
  end

endmodule
